// File: rtl/mcycle_seq_ctrl_if.sv
// Handshake and adder bus between the pipeline/datapath and the multi-cycle sequencer.
// The master side drives the requests and operands. The slave side is the sequencer.
interface mcycle_seq_ctrl_if #(parameter int width = 32);
  logic             Start;
  logic             MCycleOp;
  logic             Control;
  logic [width-1:0] a;
  logic [width-1:0] b;
  logic             cin;
  logic             Init;
  logic             Shift;
  logic             Write;
  logic             Busy;
  logic             Done;
  logic [width-1:0] s;
  logic             cout;

  modport master (
    output Start, MCycleOp, Control, a, b, cin,
    input  Init, Shift, Write, Busy, Done, s, cout
  );

  modport slave (
    input  Start, MCycleOp, Control, a, b, cin,
    output Init, Shift, Write, Busy, Done, s, cout
  );
endinterface

// File: rtl/mcycle_seq_ctrl.sv
// Sequencer for the iterative multiply/divide unit. It runs width Shift cycles per
// operation and then gives a one-cycle Done pulse. It also holds the shared decision adder.
module mcycle_seq_ctrl #(
  parameter int width = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  mcycle_seq_ctrl_if.slave   bus
);
  localparam int CNT_W = (width > 1) ? $clog2(width) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             shift_q;
  logic             done_q;
  logic             idle;

  // MCycleOp is deliberately not consulted here. Both ops share identical timing.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            cnt     <= '0;
            shift_q <= 1'b1;
            state   <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (cnt == CNT_W'(width - 1)) begin
            shift_q <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          shift_q <= 1'b0;
          done_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Init and Busy answer Start in the same cycle so the pipeline stalls without delay.
  assign idle      = (state == IDLE);
  assign bus.Init  = idle & bus.Start;
  assign bus.Busy  = (idle & bus.Start) | shift_q;
  assign bus.Shift = shift_q;
  assign bus.Write = shift_q & bus.Control;
  assign bus.Done  = done_q;

  // A subtract is requested by the caller, who passes ~x on b and sets cin=1.
  assign {bus.cout, bus.s} = (width+1)'(bus.a) + (width+1)'(bus.b) + (width+1)'(bus.cin);
endmodule

// File: tb/tb_mcycle_seq_ctrl.sv
// Randomized bench for mcycle_seq_ctrl against a cycle-index reference model.
// The model tracks the position within an operation (k) and derives every strobe from it.
module tb_mcycle_seq_ctrl;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  // Model position. -1 means idle, 1..W is Shift cycle k, and W+1 is the Done cycle.
  int   k = -1;

  mcycle_seq_ctrl_if #(.width(W)) bus ();
  mcycle_seq_ctrl #(.width(W)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

  always #5 CLK = ~CLK;

  // Result order is {Init, Shift, Write, Busy, Done}.
  function automatic logic [4:0] model_out();
    logic [4:0] e;
    if (k < 0)       e = {bus.Start, 1'b0, 1'b0, bus.Start, 1'b0};
    else if (k <= W) e = {1'b0, 1'b1, bus.Control, 1'b1, 1'b0};
    else             e = 5'b00001;
    return e;
  endfunction

  function automatic logic [4:0] obs_out();
    return {bus.Init, bus.Shift, bus.Write, bus.Busy, bus.Done};
  endfunction

  task automatic tick();
    @(posedge CLK);
    if (!Reset) begin
      if (k < 0) begin
        if (bus.Start) k = 1;
      end else if (k <= W) k++;
      else k = -1;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    Reset = 1'b1; bus.Start = 0; bus.Control = 0; bus.MCycleOp = 0;
    bus.a = '0; bus.b = '0; bus.cin = 0; k = -1;
    #2;
    e = 5'b0;
    checks++;
    if (obs_out() !== e) begin
      errors++; $display("FAIL reset obs=%b exp=%b", obs_out(), e);
    end
    tick(); tick();
    Reset = 1'b0;
    @(negedge CLK);
    checks++;
    if (obs_out() !== e) begin
      errors++; $display("FAIL reset_release obs=%b exp=%b", obs_out(), e);
    end
    tick();
  endtask

  task automatic test_single_op(input logic op);
    logic [4:0] e;
    int shifts = 0, done_at = -1, busy_at_done = 1;
    bus.MCycleOp = op;
    for (int i = 0; i < W + 4; i++) begin
      bus.Start   = (i == 0);
      bus.Control = (i % 2 == 1);
      @(negedge CLK);
      e = model_out();
      checks++;
      if (obs_out() !== e) begin
        errors++; $display("FAIL single_op%0d i=%0d obs=%b exp=%b", op, i, obs_out(), e);
      end
      if (i == 0) begin
        checks++;
        if ({bus.Init, bus.Busy} !== 2'b11) begin
          errors++; $display("FAIL start_init_busy op=%0d obs=%b exp=11", op, {bus.Init, bus.Busy});
        end
      end
      if (bus.Shift === 1'b1) shifts++;
      if (bus.Done === 1'b1) begin done_at = i; busy_at_done = bus.Busy; end
      tick();
    end
    checks++;
    if (shifts != W || done_at != W + 1 || busy_at_done != 0) begin
      errors++;
      $display("FAIL latency op=%0d shifts=%0d done_at=%0d busy=%0d exp %0d/%0d/0",
               op, shifts, done_at, busy_at_done, W, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    int inits = 0;
    bus.Start = 1'b1;
    for (int i = 0; i < 3 * (W + 2); i++) begin
      bus.Control  = 1'($urandom_range(0, 1));
      bus.MCycleOp = 1'($urandom_range(0, 1));
      @(negedge CLK);
      e = model_out();
      checks++;
      if (obs_out() !== e) begin
        errors++; $display("FAIL back_to_back i=%0d obs=%b exp=%b", i, obs_out(), e);
      end
      if (bus.Init === 1'b1) inits++;
      tick();
    end
    checks++;
    if (inits != 3) begin
      errors++; $display("FAIL back_to_back_inits obs=%0d exp=3", inits);
    end
    bus.Start = 1'b0;
    while (k >= 0) tick();
  endtask

  task automatic test_random();
    logic [4:0] e;
    for (int i = 0; i < 400; i++) begin
      bus.Start    = ($urandom_range(0, 9) == 0);
      bus.Control  = 1'($urandom_range(0, 1));
      bus.MCycleOp = 1'($urandom_range(0, 1));
      @(negedge CLK);
      e = model_out();
      checks++;
      if (obs_out() !== e) begin
        errors++; $display("FAIL random i=%0d k=%0d obs=%b exp=%b", i, k, obs_out(), e);
      end
      tick();
    end
    bus.Start = 1'b0;
    while (k >= 0) tick();
  endtask

  task automatic test_reset_mid();
    logic [4:0] e;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    while (k < 10) tick();
    // The reset is asserted between clock edges, so the strobes must drop without waiting for a clock edge.
    Reset = 1'b1; k = -1;
    #1;
    e = 5'b0;
    checks++;
    if (obs_out() !== e) begin
      errors++; $display("FAIL reset_mid_async obs=%b exp=%b", obs_out(), e);
    end
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.Done !== 1'b0) begin
        errors++; $display("FAIL reset_mid_no_done obs=%b exp=0", bus.Done);
      end
      tick();
    end
    test_single_op(1'b0);
  endtask

  task automatic test_adder();
    logic [W-1:0] av, bv, xv;
    logic         cv;
    logic [W:0]   e;
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic [W:0]   ve [3];
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h1;       ve[0] = {1'b1, 32'h0};
    va[1] = 32'h5;         vb[1] = ~32'h3;      ve[1] = {1'b1, 32'h2};
    va[2] = 32'h3;         vb[2] = ~32'h5;      ve[2] = {1'b0, 32'hFFFF_FFFE};
    for (int i = 0; i < 3; i++) begin
      bus.a = va[i]; bus.b = vb[i]; bus.cin = (i != 0);
      #1;
      checks++;
      if ({bus.cout, bus.s} !== ve[i]) begin
        errors++; $display("FAIL adder_vec%0d obs=%h exp=%h", i, {bus.cout, bus.s}, ve[i]);
      end
    end
    for (int i = 0; i < 60; i++) begin
      av = $urandom; bv = $urandom; cv = 1'($urandom_range(0, 1));
      bus.a = av; bus.b = bv; bus.cin = cv;
      #1;
      e = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
      checks++;
      if ({bus.cout, bus.s} !== e) begin
        errors++; $display("FAIL adder_add a=%h b=%h cin=%b obs=%h exp=%h", av, bv, cv, {bus.cout, bus.s}, e);
      end
      xv = (i % 4 == 0) ? av : 32'($urandom);
      bus.b = ~xv; bus.cin = 1'b1;
      #1;
      checks++;
      if (bus.s !== av - xv || bus.cout !== (av >= xv)) begin
        errors++;
        $display("FAIL adder_sub a=%h x=%h obs=%b/%h exp=%b/%h", av, xv, bus.cout, bus.s, av >= xv, av - xv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_adder();
    test_single_op(1'b0);
    test_single_op(1'b1);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
